rail_fence_encrypt: RTL and testbench



---
 rtl/rail_fence_encrypt.sv | 177 +++++++++++++++++
 tb/tb_rail_fence_encrypt.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/rail_fence_encrypt.sv
// Streaming rail-fence encryptor: buffers one message, then re-emits it in zig-zag rail order.
// Optional RAIL_FENCE_OVF_ERR_EN adds ovf_err, a one-cycle flag for messages truncated at MAX_LEN.
module rail_fence_encrypt #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned MAX_LEN = 64,
    parameter int unsigned KEY_W   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [KEY_W-1:0]  key,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    input  logic              out_ready,
`ifdef RAIL_FENCE_OVF_ERR_EN
    output logic              ovf_err,
`endif
    output logic              busy
);

    localparam int unsigned ADDR_W = $clog2(MAX_LEN);
    localparam int unsigned LEN_W  = $clog2(MAX_LEN) + 1;
    localparam logic [LEN_W-1:0] LAST_IDX = LEN_W'(MAX_LEN - 1);

    typedef enum logic [1:0] {LOAD, SETUP, EMIT} state_t;

    state_t              state_q;
    logic [DATA_W-1:0]   buf_q [MAX_LEN];
    logic [LEN_W-1:0]    len_q;
    logic [LEN_W-1:0]    pos_q;
    logic [LEN_W-1:0]    cyc_q;
    logic [LEN_W-1:0]    cnt_q;
    logic [KEY_W-1:0]    rail_q;
    logic [KEY_W-1:0]    k_q;
    logic                phase_q;
    logic                in_ready_q;
    logic                out_valid_q;
    logic [DATA_W-1:0]   out_data_q;
    logic                out_last_q;
    logic                busy_q;
`ifdef RAIL_FENCE_OVF_ERR_EN
    logic                ovf_q;
`endif

    logic                in_fire;
    logic                close_msg;
    logic                done;
    logic                load_slot;
    logic                rail_last;
    logic [LEN_W-1:0]    rail2;
    logic [LEN_W-1:0]    step_d;
    logic [LEN_W-1:0]    pos_d;
    logic [LEN_W-1:0]    next_rail_pos;

    assign in_fire       = in_valid && in_ready_q && (state_q == LOAD);
    assign close_msg     = in_fire && (in_last || (len_q == LAST_IDX));
    assign done          = (state_q == EMIT) && out_valid_q && out_ready && out_last_q;
    assign load_slot     = (state_q == EMIT) && (!out_valid_q || out_ready) && (cnt_q != len_q);
    assign rail_last     = (rail_q == (k_q - KEY_W'(1)));
    assign rail2         = LEN_W'(rail_q) << 1;
    assign pos_d         = pos_q + step_d;
    assign next_rail_pos = LEN_W'(rail_q) + LEN_W'(1);

    // Zig-zag stride for the current rail; inner rails alternate down/up strides.
    always_comb begin
        step_d = cyc_q;
        if (cyc_q == '0) begin
            step_d = LEN_W'(1);
        end else if ((rail_q != '0) && !rail_last) begin
            step_d = phase_q ? rail2 : (cyc_q - rail2);
        end
    end

    // Message buffer is not reset; len_q alone decides what is valid.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            buf_q[len_q[ADDR_W-1:0]] <= in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= LOAD;
            len_q       <= '0;
            pos_q       <= '0;
            cyc_q       <= '0;
            cnt_q       <= '0;
            rail_q      <= '0;
            k_q         <= KEY_W'(1);
            phase_q     <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
`ifdef RAIL_FENCE_OVF_ERR_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                LOAD: begin
                    if (in_fire) begin
                        len_q  <= len_q + LEN_W'(1);
                        busy_q <= 1'b1;
                    end
                    if (close_msg) begin
                        k_q        <= (key == '0) ? KEY_W'(1) : key;
                        in_ready_q <= 1'b0;
                        state_q    <= SETUP;
`ifdef RAIL_FENCE_OVF_ERR_EN
                        ovf_q      <= !in_last;
`endif
                    end
                end
                SETUP: begin
                    cyc_q   <= (LEN_W'(k_q) - LEN_W'(1)) << 1;
                    rail_q  <= '0;
                    pos_q   <= '0;
                    phase_q <= 1'b0;
                    cnt_q   <= '0;
                    state_q <= EMIT;
`ifdef RAIL_FENCE_OVF_ERR_EN
                    ovf_q   <= 1'b0;
`endif
                end
                EMIT: begin
                    if (done) begin
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        len_q       <= '0;
                        state_q     <= LOAD;
                    end else if (load_slot) begin
                        if (pos_q < len_q) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= buf_q[pos_q[ADDR_W-1:0]];
                            out_last_q  <= (cnt_q == (len_q - LEN_W'(1)));
                            cnt_q       <= cnt_q + LEN_W'(1);
                            if (pos_d >= len_q) begin
                                rail_q  <= rail_q + KEY_W'(1);
                                pos_q   <= next_rail_pos;
                                phase_q <= 1'b0;
                            end else begin
                                pos_q   <= pos_d;
                                phase_q <= !phase_q;
                            end
                        end else begin
                            // Empty rail: one bubble, then move on.
                            out_valid_q <= 1'b0;
                            rail_q      <= rail_q + KEY_W'(1);
                            pos_q       <= next_rail_pos;
                            phase_q     <= 1'b0;
                        end
                    end else if (out_valid_q && out_ready) begin
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= LOAD;
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_last  = out_last_q;
    assign busy      = busy_q;
`ifdef RAIL_FENCE_OVF_ERR_EN
    assign ovf_err   = ovf_q;
`endif

endmodule

// File: tb/tb_rail_fence_encrypt.sv
// Self-checking bench for rail_fence_encrypt: directed message table plus stall, overflow,
// mid-stream reset and single-character sequences.
module tb_rail_fence_encrypt;

    typedef logic [7:0] bq_t [$];
    typedef struct {
        string msg;
        int    key;
        string exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] key;
    logic       in_valid;
    logic [7:0] in_data;
    logic       in_last;
    logic       in_ready;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_last;
    logic       out_ready;
    logic       busy;
    int         tests = 0;
    int         fails = 0;
    int         ovf_cnt = 0;
`ifdef RAIL_FENCE_OVF_ERR_EN
    logic       ovf_err;
`endif

    always #5 clk = ~clk;

    rail_fence_encrypt dut (
        .clk       (clk),
        .rst       (rst),
        .key       (key),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_ready (out_ready),
`ifdef RAIL_FENCE_OVF_ERR_EN
        .ovf_err   (ovf_err),
`endif
        .busy      (busy)
    );

`ifdef RAIL_FENCE_OVF_ERR_EN
    always @(negedge clk) if (ovf_err === 1'b1) ovf_cnt++;
`endif

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference: assign each character its zig-zag row, then read rows top to bottom.
    function automatic bq_t rf_model(input bq_t p, input int key_in);
        bq_t q;
        int  k;
        int  per;
        int  row;
        k = (key_in == 0) ? 1 : key_in;
        if (k == 1) return p;
        per = 2 * k - 2;
        for (int r = 0; r < k; r++) begin
            for (int i = 0; i < p.size(); i++) begin
                row = i % per;
                if (row >= k) row = per - row;
                if (row == r) q.push_back(p[i]);
            end
        end
        return q;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_q(input string name, input bq_t act, input bq_t exp);
        int bad;
        bad = -1;
        for (int i = 0; i < exp.size(); i++) begin
            if (bad < 0 && (i >= act.size() || act[i] !== exp[i])) bad = i;
        end
        tests++;
        if (act.size() != exp.size() || bad >= 0) begin
            fails++;
            $display("FAIL %s: got %0d chars expected %0d, first bad index %0d", name,
                     act.size(), exp.size(), bad);
        end
    endtask

    task automatic send(input bq_t d, input int k, input bit mark_last);
        int w;
        for (int i = 0; i < d.size(); i++) begin
            @(negedge clk);
            w = 0;
            while (!in_ready && w < 4000) begin
                @(negedge clk);
                w++;
            end
            chk("send_ready_timeout", 32'(in_ready), 32'd1);
            in_valid = 1'b1;
            in_data  = d[i];
            in_last  = mark_last && (i == d.size() - 1);
            key      = 4'(k);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic recv(input int max_n, input bit stall, output bq_t got,
                        output int last_idx, output int stall_err, output bit to);
        bit         held_v;
        logic [7:0] held_d;
        logic       held_l;
        held_v = 1'b0;
        held_d = '0;
        held_l = 1'b0;
        got.delete();
        last_idx  = -1;
        stall_err = 0;
        to        = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (held_v && (!out_valid || out_data !== held_d || out_last !== held_l)) stall_err++;
            out_ready = stall ? 1'($urandom_range(0, 1)) : 1'b1;
            held_v = out_valid && !out_ready;
            held_d = out_data;
            held_l = out_last;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                if (out_last) last_idx = got.size() - 1;
                if (out_last || (max_n > 0 && got.size() == max_n)) begin
                    to = 1'b0;
                    break;
                end
            end
        end
    endtask

    initial begin
        vec_t vecs [6];
        bq_t  got;
        bq_t  got2;
        bq_t  exp;
        bq_t  p70;
        bq_t  part;
        int   last_idx;
        int   serr;
        bit   to;

        vecs[0] = '{"WEAREDISCOVEREDFLEEATONCE", 3, "WECRLTEERDSOEEFEAOCAIVDEN"};
        vecs[1] = '{"HELLO", 2, "HLOEL"};
        vecs[2] = '{"ABC", 1, "ABC"};
        vecs[3] = '{"ABC", 5, "ABC"};
        vecs[4] = '{"ABCDEFGH", 3, "AEBDFHCG"};
        vecs[5] = '{"ABCDEFGH", 0, "ABCDEFGH"};

        rst = 1'b1; key = '0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;

        // Back-to-back directed messages.
        foreach (vecs[v]) begin
            send(s2q(vecs[v].msg), vecs[v].key, 1'b1);
            recv(0, 1'b0, got, last_idx, serr, to);
            chk_q($sformatf("vec%0d_data", v), got, s2q(vecs[v].exp));
            chk($sformatf("vec%0d_last", v), 32'(last_idx), 32'(vecs[v].exp.len() - 1));
            chk($sformatf("vec%0d_timeout", v), 32'(to), 32'd0);
            @(negedge clk);
            chk($sformatf("vec%0d_busy_low", v), 32'(busy), 32'd0);
            chk($sformatf("vec%0d_restart_ready", v), 32'(in_ready), 32'd1);
        end

        // Random backpressure on the output.
        send(s2q("WEAREDISCOVEREDFLEEATONCE"), 3, 1'b1);
        recv(0, 1'b1, got, last_idx, serr, to);
        out_ready = 1'b1;
        chk_q("stall_data", got, s2q("WECRLTEERDSOEEFEAOCAIVDEN"));
        chk("stall_last", 32'(last_idx), 32'd24);
        chk("stall_stable", 32'(serr), 32'd0);
        chk("stall_timeout", 32'(to), 32'd0);

        // Single character message.
        send(s2q("Z"), 3, 1'b1);
        chk("single_busy_high", 32'(busy), 32'd1);
        recv(0, 1'b0, got, last_idx, serr, to);
        chk_q("single_data", got, s2q("Z"));
        chk("single_last", 32'(last_idx), 32'd0);
        @(negedge clk);
        chk("single_busy_low", 32'(busy), 32'd0);

        // Overflow: 70 characters, only the 70th marked last.
        for (int i = 0; i < 70; i++) p70.push_back(8'(i));
        fork
            send(p70, 4, 1'b1);
            begin
                recv(0, 1'b0, got, last_idx, serr, to);
                chk("ovf_msg1_last", 32'(last_idx), 32'd63);
                chk("ovf_msg1_timeout", 32'(to), 32'd0);
                recv(0, 1'b0, got2, last_idx, serr, to);
                chk("ovf_msg2_last", 32'(last_idx), 32'd5);
                chk("ovf_msg2_timeout", 32'(to), 32'd0);
            end
        join
        part = p70[0:63];
        chk_q("ovf_msg1_data", got, rf_model(part, 4));
        part = p70[64:69];
        exp = '{8'h40, 8'h41, 8'h45, 8'h42, 8'h44, 8'h43};
        chk_q("ovf_msg2_data", got2, exp);
`ifdef RAIL_FENCE_OVF_ERR_EN
        chk("ovf_err_pulses", 32'(ovf_cnt), 32'd1);
`endif
        @(negedge clk);

        // Reset mid-emission after ten characters.
        send(s2q("WEAREDISCOVEREDFLEEATONCE"), 3, 1'b1);
        recv(10, 1'b0, got, last_idx, serr, to);
        chk_q("rst_mid_prefix", got, s2q("WECRLTEERD"));
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'd0);
        chk("rst_mid_in_ready", 32'(in_ready), 32'd1);
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_out_last", 32'(out_last), 32'd0);
        rst = 1'b0;
        send(s2q("HELLO"), 2, 1'b1);
        recv(0, 1'b0, got, last_idx, serr, to);
        chk_q("rst_after_data", got, s2q("HLOEL"));
        chk("rst_after_last", 32'(last_idx), 32'd4);

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
